// File: rtl/pair_sweep_pkg.sv
// Shared definitions for the pair sweep scheduler: FSM state encoding,
// default coordinate-store capacity and the pair-count helper.
package pair_sweep_pkg;

  localparam int DEFAULT_MAX_POINTS = 512;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sweep_state_t;

  // Number of unordered pairs (i < j) over n points.
  function automatic int unsigned pair_total(input int unsigned n);
    if (n < 2) return 0;
    return (n * (n - 1)) / 2;
  endfunction

endpackage

// File: rtl/pair_cursor.sv
// Row-major (i, j) cursor over all pairs with i < j. Loads (0,1) on start,
// steps on every issue and flags the final pair (N-2, N-1).
module pair_cursor
  import pair_sweep_pkg::*;
#(
  parameter int IDX_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  input  logic [IDX_W:0]   num_points,
  output logic [IDX_W-1:0] i,
  output logic [IDX_W-1:0] j,
  output logic             last
);

  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_TWO = IDX_W'(2);
  localparam logic [IDX_W:0]   N_ONE   = (IDX_W + 1)'(1);
  localparam logic [IDX_W:0]   N_TWO   = (IDX_W + 1)'(2);

  logic [IDX_W:0] n_minus_1;
  logic [IDX_W:0] n_minus_2;
  logic           row_end;

  // Comparisons run one bit wider so N = MAX_POINTS is representable.
  assign n_minus_1 = num_points - N_ONE;
  assign n_minus_2 = num_points - N_TWO;
  assign row_end   = ({1'b0, j} >= n_minus_1);
  assign last      = ({1'b0, i} == n_minus_2) && ({1'b0, j} == n_minus_1);

  // Cursor register: restart at (0,1) on load, otherwise step row-major per issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i <= '0;
      j <= '0;
    end else if (load) begin
      i <= '0;
      j <= IDX_ONE;
    end else if (advance) begin
      if (!row_end) begin
        j <= j + IDX_ONE;
      end else begin
        i <= i + IDX_ONE;
        j <= i + IDX_TWO;
      end
    end
  end

endmodule

// File: rtl/pair_sweep_scheduler.sv
// Pair sweep scheduler: walks all pairs i < j, issues coordinate-store reads,
// presents each pair through valid/ready, limits in-flight pairs with credits
// and pulses done once the downstream pipeline has drained.
// Optional feature macro: PAIR_SWEEP_STATS_EN adds stall_cycles/sweep_cycles.
module pair_sweep_scheduler
  import pair_sweep_pkg::*;
#(
  parameter int MAX_POINTS   = DEFAULT_MAX_POINTS,
  parameter int IDX_W        = $clog2(MAX_POINTS),
  parameter int MAX_INFLIGHT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [IDX_W:0]     num_points,
  output logic               busy,
  output logic               done,
  output logic               rd_en,
  output logic [IDX_W-1:0]   rd_addr_a,
  output logic [IDX_W-1:0]   rd_addr_b,
  output logic               pair_valid,
  input  logic               pair_ready,
  output logic [IDX_W-1:0]   pair_i,
  output logic [IDX_W-1:0]   pair_j,
  output logic               pair_last,
  input  logic               retire,
  output logic [2*IDX_W:0]   pair_count
`ifdef PAIR_SWEEP_STATS_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        sweep_cycles
`endif
);

  localparam int                  CREDIT_W   = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CREDIT_W-1:0] CREDIT_ONE = CREDIT_W'(1);
  localparam logic [IDX_W:0]      N_TWO      = (IDX_W + 1)'(2);
  localparam logic [2*IDX_W:0]    COUNT_ONE  = (2 * IDX_W + 1)'(1);

  sweep_state_t        state_reg;
  sweep_state_t        state_next;
  logic [IDX_W:0]      n_reg;
  logic [IDX_W-1:0]    cur_i;
  logic [IDX_W-1:0]    cur_j;
  logic                cur_last;
  logic                cursor_load;
  logic                issue_ok;
  logic                credit_ok;
  logic                handshake;
  logic                retire_ok;
  logic [CREDIT_W-1:0] inflight_reg;
  logic                pair_valid_reg;
  logic                pair_last_reg;
  logic [IDX_W-1:0]    pair_i_reg;
  logic [IDX_W-1:0]    pair_j_reg;
  logic [2*IDX_W:0]    pair_count_reg;

  pair_cursor #(
    .IDX_W(IDX_W)
  ) u_cursor (
    .clk       (clk),
    .rst       (rst),
    .load      (cursor_load),
    .advance   (issue_ok),
    .num_points(n_reg),
    .i         (cur_i),
    .j         (cur_j),
    .last      (cur_last)
  );

  // The presented-but-unaccepted pair already holds a credit slot.
  assign credit_ok = (int'(inflight_reg) + int'(pair_valid_reg)) < MAX_INFLIGHT;
  assign handshake = pair_valid_reg && pair_ready;
  // A retire with nothing in flight is a protocol error and is dropped.
  assign retire_ok = retire && (inflight_reg != '0);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // FSM next state and issue decision.
  always_comb begin
    state_next  = state_reg;
    cursor_load = 1'b0;
    issue_ok    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          cursor_load = 1'b1;
          // With fewer than two points nothing is issued; the empty drain
          // completes at once, giving the same one-cycle busy window.
          state_next  = (num_points < N_TWO) ? DRAIN : SWEEP;
        end
      end
      SWEEP: begin
        issue_ok = (!pair_valid_reg || pair_ready) && credit_ok;
        if (issue_ok && cur_last) state_next = DRAIN;
      end
      DRAIN: begin
        if (!pair_valid_reg && (inflight_reg == '0)) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output register: capture the pair whose read was issued, clear on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_valid_reg <= 1'b0;
      pair_last_reg  <= 1'b0;
      pair_i_reg     <= '0;
      pair_j_reg     <= '0;
    end else if (issue_ok) begin
      pair_valid_reg <= 1'b1;
      pair_last_reg  <= cur_last;
      pair_i_reg     <= cur_i;
      pair_j_reg     <= cur_j;
    end else if (handshake) begin
      pair_valid_reg <= 1'b0;
      pair_last_reg  <= 1'b0;
    end
  end

  // Credit counter: +1 per handshake, -1 per valid retire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_reg <= '0;
    end else if (handshake && !retire_ok) begin
      inflight_reg <= inflight_reg + CREDIT_ONE;
    end else if (!handshake && retire_ok) begin
      inflight_reg <= inflight_reg - CREDIT_ONE;
    end
  end

  // Latched point count and handed-over pair counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_reg          <= '0;
      pair_count_reg <= '0;
    end else if (cursor_load) begin
      n_reg          <= num_points;
      pair_count_reg <= '0;
    end else if (handshake) begin
      pair_count_reg <= pair_count_reg + COUNT_ONE;
    end
  end

`ifdef PAIR_SWEEP_STATS_EN
  logic [31:0] stall_cycles_reg;
  logic [31:0] sweep_cycles_reg;

  // Sweep statistics: cleared on accepted start, frozen once the sweep ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_reg <= '0;
      sweep_cycles_reg <= '0;
    end else if ((state_reg == IDLE) && start) begin
      stall_cycles_reg <= '0;
      sweep_cycles_reg <= '0;
    end else begin
      if ((state_reg == SWEEP) && !issue_ok) stall_cycles_reg <= stall_cycles_reg + 32'd1;
      if (busy) sweep_cycles_reg <= sweep_cycles_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_reg;
  assign sweep_cycles = sweep_cycles_reg;
`endif

  assign busy       = (state_reg == SWEEP) || (state_reg == DRAIN);
  assign done       = (state_reg == DONE);
  assign rd_en      = issue_ok;
  assign rd_addr_a  = cur_i;
  assign rd_addr_b  = cur_j;
  assign pair_valid = pair_valid_reg;
  assign pair_last  = pair_last_reg;
  assign pair_i     = pair_i_reg;
  assign pair_j     = pair_j_reg;
  assign pair_count = pair_count_reg;

  // A completed sweep must have handed over exactly N(N-1)/2 pairs.
  assert property (@(posedge clk) disable iff (rst)
    (state_reg == DONE) |-> (32'(pair_count_reg) == pair_total(32'(n_reg))));

endmodule

// File: tb/tb_pair_sweep_scheduler.sv
// Directed bench for pair_sweep_scheduler: row-major pair order, handshake
// stalls, credit limit, short sweeps, mid-sweep reset and start-while-busy.
module tb_pair_sweep_scheduler;

  localparam int IDX_W = 9;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [IDX_W:0]     num_points;
  logic               busy;
  logic               done;
  logic               rd_en;
  logic [IDX_W-1:0]   rd_addr_a;
  logic [IDX_W-1:0]   rd_addr_b;
  logic               pair_valid;
  logic               pair_ready;
  logic [IDX_W-1:0]   pair_i;
  logic [IDX_W-1:0]   pair_j;
  logic               pair_last;
  logic               retire;
  logic [2*IDX_W:0]   pair_count;
`ifdef PAIR_SWEEP_STATS_EN
  logic [31:0]        stall_cycles;
  logic [31:0]        sweep_cycles;
`endif

  pair_sweep_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_points  (num_points),
    .busy        (busy),
    .done        (done),
    .rd_en       (rd_en),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .pair_valid  (pair_valid),
    .pair_ready  (pair_ready),
    .pair_i      (pair_i),
    .pair_j      (pair_j),
    .pair_last   (pair_last),
    .retire      (retire),
    .pair_count  (pair_count)
`ifdef PAIR_SWEEP_STATS_EN
    ,
    .stall_cycles(stall_cycles),
    .sweep_cycles(sweep_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Bench state: cycle index since the cycle after start, reference cursor, tallies.
  int   cyc, hs_count, rd_en_count, valid_cycles, done_count, done_cyc;
  int   first_hs_cyc, last_hs_cyc, last_retire_cyc, stall_exp;
  int   exp_i, exp_j, exp_n, exp_total;
  int   ready_mode, retire_lat, glitch_cyc;
  logic force_retire, hs_prev, prev_valid, prev_ready, last_seen;
  logic [3:0] hist;
  logic [IDX_W-1:0] prev_i, prev_j;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One clock: drive ready/retire/start after the edge, then observe.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    hist = {hist[2:0], hs_prev};
    case (ready_mode)
      0:       pair_ready = 1'b1;
      1:       pair_ready = ((cyc % 3) == 1);
      default: pair_ready = 1'b0;
    endcase
    retire = force_retire || ((retire_lat > 0) ? hist[retire_lat - 1] : 1'b0);
    start  = (cyc == glitch_cyc);
    if (cyc == glitch_cyc) num_points = 10'd2;
    #1;
    if (rd_en) rd_en_count++;
    if (pair_valid) valid_cycles++;
    if (!pair_valid) check_eq("last_without_valid", pair_last, 0);
    if (prev_valid && !prev_ready) begin
      check_eq("stall_valid", pair_valid, 1);
      check_eq("stall_i", pair_i, prev_i);
      check_eq("stall_j", pair_j, prev_j);
    end
    if (pair_valid && pair_last) last_seen = 1'b1;
    if (!last_seen && pair_valid && !pair_ready) stall_exp++;
    hs_prev = pair_valid && pair_ready;
    if (hs_prev) begin
      check_eq("pair_i", pair_i, exp_i);
      check_eq("pair_j", pair_j, exp_j);
      check_eq("pair_last", pair_last, (hs_count == exp_total - 1));
      if (hs_count == 0) first_hs_cyc = cyc;
      last_hs_cyc = cyc;
      hs_count++;
      if (exp_j < exp_n - 1) begin
        exp_j++;
      end else begin
        exp_i++;
        exp_j = exp_i + 1;
      end
    end
    if (retire) last_retire_cyc = cyc;
    if (done) begin
      check_eq("busy_at_done", busy, 0);
      done_count++;
      done_cyc = cyc;
    end
    prev_valid = pair_valid;
    prev_ready = pair_ready;
    prev_i     = pair_i;
    prev_j     = pair_j;
  endtask

  // Pulse start with N; checks the T+1 cycle and the first presented pair.
  task automatic start_sweep(input int n, input int total);
    exp_n = n; exp_total = total; exp_i = 0; exp_j = 1;
    hs_count = 0; done_count = 0; done_cyc = -1; valid_cycles = 0;
    first_hs_cyc = -1; last_hs_cyc = -1; last_retire_cyc = -1;
    stall_exp = 0; last_seen = 1'b0; hist = '0; hs_prev = 1'b0; force_retire = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1; num_points = n[IDX_W:0]; retire = 1'b0; pair_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    #1;
    check_eq("busy_after_start", busy, 1);
    check_eq("valid_after_start", pair_valid, 0);
    check_eq("rd_en_after_start", rd_en, (n >= 2));
    if (n >= 2) begin
      check_eq("first_addr_a", rd_addr_a, 0);
      check_eq("first_addr_b", rd_addr_b, 1);
    end
    rd_en_count = rd_en ? 1 : 0;
    prev_valid = pair_valid; prev_ready = pair_ready; prev_i = pair_i; prev_j = pair_j;
    tick();
    check_eq("first_valid", pair_valid, (n >= 2));
  endtask

  task automatic run_until_done(input int budget);
    int k = 0;
    while (done_count == 0 && k < budget) begin
      tick();
      k++;
    end
    check_eq("done_seen", done_count, 1);
    tick();
    tick();
    check_eq("done_single_pulse", done_count, 1);
    check_eq("pair_count_final", pair_count, exp_total);
    check_eq("handshakes_total", hs_count, exp_total);
`ifdef PAIR_SWEEP_STATS_EN
    check_eq("stall_cycles", stall_cycles, stall_exp);
    check_eq("sweep_cycles", sweep_cycles, done_cyc);
`endif
  endtask

  // Assert rst between edges and check every output clears immediately.
  task automatic async_reset_check(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_rd_en"}, rd_en, 0);
    check_eq({tag, "_valid"}, pair_valid, 0);
    check_eq({tag, "_last"}, pair_last, 0);
    check_eq({tag, "_count"}, pair_count, 0);
    check_eq({tag, "_pair_i"}, pair_i, 0);
    check_eq({tag, "_pair_j"}, pair_j, 0);
    check_eq({tag, "_addr_a"}, rd_addr_a, 0);
    check_eq({tag, "_addr_b"}, rd_addr_b, 0);
    retire = 1'b0; pair_ready = 1'b0; start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; num_points = '0; pair_ready = 1'b0; retire = 1'b0;
    ready_mode = 0; retire_lat = 2; glitch_cyc = -1; force_retire = 1'b0;
    hist = '0; hs_prev = 1'b0; cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_rd_en", rd_en, 0);
    check_eq("reset_valid", pair_valid, 0);
    check_eq("reset_count", pair_count, 0);
    rst = 1'b0;

    // N=4, ready held high, retire two cycles after each handshake.
    start_sweep(4, 6);
    run_until_done(60);
    check_eq("n4_rd_en_count", rd_en_count, 6);
    check_eq("n4_back_to_back", last_hs_cyc - first_hs_cyc, 5);
    check_eq("n4_done_after_retire", done_cyc - last_retire_cyc, 2);

    // N=1 and N=0: nothing issued, done two cycles after start.
    start_sweep(1, 0);
    run_until_done(10);
    check_eq("n1_done_cyc", done_cyc, 1);
    check_eq("n1_rd_en_count", rd_en_count, 0);
    check_eq("n1_valid_cycles", valid_cycles, 0);
    start_sweep(0, 0);
    run_until_done(10);
    check_eq("n0_done_cyc", done_cyc, 1);
    check_eq("n0_rd_en_count", rd_en_count, 0);
    check_eq("n0_valid_cycles", valid_cycles, 0);

    // N=5, ready toggling 1,0,0 with a start pulse mid-sweep that must be ignored.
    ready_mode = 1;
    glitch_cyc = 4;
    start_sweep(5, 10);
    run_until_done(200);
    glitch_cyc = -1;
    check_eq("n5_done_after_retire", done_cyc - last_retire_cyc, 2);
    check_eq("n5_rd_en_count", rd_en_count, 10);

    // Credit limit: retire withheld allows exactly MAX_INFLIGHT handshakes.
    ready_mode = 0;
    retire_lat = 0;
    start_sweep(8, 28);
    repeat (10) tick();
    check_eq("credit_hs", hs_count, 4);
    check_eq("credit_rd_en", rd_en_count, 4);
    check_eq("credit_rd_en_low", rd_en, 0);
    force_retire = 1'b1;
    tick();
    force_retire = 1'b0;
    repeat (6) tick();
    check_eq("credit_release_hs", hs_count, 5);
    check_eq("credit_release_rd_en", rd_en_count, 5);
    async_reset_check("credit_rst");

    // N=6 abandoned by reset after the 7th handshake, then a clean N=3 sweep.
    retire_lat = 2;
    start_sweep(6, 15);
    for (int k = 0; k < 50 && hs_count < 7; k++) tick();
    check_eq("n6_seventh_hs", hs_count, 7);
    async_reset_check("midsweep_rst");
    start_sweep(3, 3);
    run_until_done(60);
    check_eq("n3_done_after_retire", done_cyc - last_retire_cyc, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
